// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending/countdown tracking, decode stall and writeback-slot arbitration for Issue.
// Optional HAZARD_SCOREBOARD_BYPASS_EN: a register one cycle from completion no longer stalls Decode.
module hazard_scoreboard #(
   parameter int LATW  = 3,
   parameter int NSLOT = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [4:0]      id_hd_ass_addra,
   input  logic            id_hd_check_a,
   input  logic [4:0]      id_hd_ass_addrb,
   input  logic            id_hd_check_b,
   output logic            hd_id_stall,
   input  logic            iss_hd_req,
   input  logic            iss_hd_writereg,
   input  logic [4:0]      iss_hd_regdest,
   input  logic [LATW-1:0] iss_hd_latency,
   output logic            hd_iss_grant,
   output logic [31:0]     hd_busy_mask
);
   logic [31:0]      r_pend;
   logic [LATW-1:0]  r_cnt [32];
   logic [NSLOT-1:0] r_slot;
   logic [LATW-1:0]  w_lat;
   logic [NSLOT-1:0] w_slot_sh;
   logic [31:0]      w_stall_pend;
   logic             w_waw;
   logic             w_slot_busy;
   logic             w_load;
   assign w_lat       = (iss_hd_latency == '0) ? LATW'(1) : iss_hd_latency;
   // Reservations are checked in the post-shift frame, where index L-1 is the bus slot this grant would occupy.
   assign w_slot_sh   = r_slot >> 1;
   assign w_slot_busy = w_slot_sh[w_lat - LATW'(1)];
   assign w_waw       = r_pend[iss_hd_regdest] && (r_cnt[iss_hd_regdest] >= w_lat);
   assign hd_iss_grant = iss_hd_req && (!iss_hd_writereg || (!w_slot_busy && !w_waw));
   assign w_load      = hd_iss_grant && iss_hd_writereg;
   assign hd_busy_mask = r_pend;
   always_comb begin
      w_stall_pend = r_pend;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
      for (int i = 0; i < 32; i++)
         w_stall_pend[i] = r_pend[i] && (r_cnt[i] != LATW'(1));
`endif
   end
   assign hd_id_stall = (id_hd_check_a && w_stall_pend[id_hd_ass_addra]) ||
                        (id_hd_check_b && w_stall_pend[id_hd_ass_addrb]);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_slot <= '0;
         for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      end else begin
         r_slot <= w_slot_sh | (w_load ? (NSLOT'(1) << (w_lat - LATW'(1))) : '0);
         // A new load wins over an expiring count; r0 keeps no state.
         for (int i = 1; i < 32; i++) begin
            if (w_load && iss_hd_regdest == 5'(i)) begin
               r_pend[i] <= 1'b1;
               r_cnt[i]  <= w_lat;
            end else if (r_pend[i]) begin
               r_cnt[i] <= r_cnt[i] - LATW'(1);
               if (r_cnt[i] == LATW'(1)) r_pend[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench; model tracks landing edges per register and per writeback bus slot.
module tb_hazard_scoreboard;
   localparam int LATW = 3;
   typedef struct packed {
      logic        stall;
      logic        grant;
      logic [31:0] mask;
   } exp_t;
   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [4:0]      addra = '0, addrb = '0, regdest = '0;
   logic            check_a = 1'b0, check_b = 1'b0, req = 1'b0, writereg = 1'b0;
   logic [LATW-1:0] latency = '0;
   logic            stall, grant;
   logic [31:0]     mask;
   int              n_tests = 0;
   int              n_fail = 0;
   int              edge_cnt = 0;
   int              land [32];
   bit              slot_used [int];
   exp_t            exp_q [$];
   hazard_scoreboard #(.LATW(LATW), .NSLOT(8)) dut (
      .clock(clock), .reset(reset),
      .id_hd_ass_addra(addra), .id_hd_check_a(check_a),
      .id_hd_ass_addrb(addrb), .id_hd_check_b(check_b),
      .hd_id_stall(stall),
      .iss_hd_req(req), .iss_hd_writereg(writereg),
      .iss_hd_regdest(regdest), .iss_hd_latency(latency),
      .hd_iss_grant(grant), .hd_busy_mask(mask)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic int rem(input int r);
      return (r == 0) ? 0 : land[r] - edge_cnt;
   endfunction
   function automatic bit opnd_stall(input logic c, input logic [4:0] a);
      int k = rem(int'(a));
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
      return c && k > 1;
`else
      return c && k > 0;
`endif
   endfunction
   task automatic model_clear();
      for (int i = 0; i < 32; i++) land[i] = 0;
      slot_used.delete();
      edge_cnt = 0;
   endtask
   task automatic step(input logic r, input logic w, input logic [4:0] rd, input int l,
                       input logic ca, input logic [4:0] aa, input logic cb, input logic [4:0] ab);
      exp_t e, got;
      int   le, tgt;
      req = r; writereg = w; regdest = rd; latency = l[LATW-1:0];
      check_a = ca; addra = aa; check_b = cb; addrb = ab;
      le  = (l == 0) ? 1 : l;
      tgt = edge_cnt + 1 + le;
      e.stall = opnd_stall(ca, aa) || opnd_stall(cb, ab);
      e.grant = r && (!w || (!slot_used.exists(tgt) && !(rem(int'(rd)) > 0 && rem(int'(rd)) >= le)));
      for (int i = 0; i < 32; i++) e.mask[i] = rem(i) > 0;
      exp_q.push_back(e);
      @(negedge clock);
      got = exp_q.pop_front();
      chk("stall", {31'b0, stall}, {31'b0, got.stall});
      chk("grant", {31'b0, grant}, {31'b0, got.grant});
      chk("busy_mask", mask, got.mask);
      @(posedge clock);
      if (got.grant && w) begin
         slot_used[tgt] = 1'b1;
         if (rd != 0) land[rd] = tgt;
      end
      edge_cnt++;
      #1;
   endtask
   task automatic idle(input int n, input logic [4:0] a);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, a, 0, 0);
   endtask
   initial begin
      model_clear();
      req = 1'b1; writereg = 1'b1; regdest = 5'd3; latency = 3'd2; check_a = 1'b1; addra = 5'd3;
      #2;
      chk("rst_mask", mask, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_grant", {31'b0, grant}, 32'h1);
      req = 1'b0;
      @(negedge clock); @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      // single write with L=3 then Decode reading it
      step(1, 1, 5, 3, 1, 5, 0, 0);
      idle(5, 5);
      // r0 write never stalls but holds a slot
      step(1, 1, 0, 2, 1, 0, 0, 0);
      step(1, 1, 0, 1, 1, 0, 0, 0);
      step(1, 1, 0, 2, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(4, 0);
      // back-to-back slot conflicts
      step(1, 1, 1, 4, 0, 0, 0, 0);
      step(1, 1, 2, 4, 0, 0, 0, 0);
      idle(6, 1);
      step(1, 1, 3, 4, 0, 0, 0, 0);
      step(1, 1, 4, 3, 0, 0, 0, 0);
      step(1, 1, 4, 0, 1, 3, 0, 0);
      idle(6, 3);
      // WAW on r7, then operand B gating
      step(1, 1, 7, 5, 0, 0, 0, 0);
      step(1, 1, 7, 2, 0, 0, 0, 0);
      step(1, 1, 7, 6, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 7);
      step(0, 0, 0, 0, 0, 0, 1, 7);
      idle(7, 7);
      // bypass window on r9
      step(1, 1, 9, 2, 0, 0, 0, 0);
      idle(3, 9);
      for (int i = 0; i < 60; i++)
         step(1'($urandom), 1'($urandom), 5'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 12)), 1'($urandom), 5'($urandom_range(0, 12)));
      idle(8, 0);
      // asynchronous reset mid-countdown
      step(1, 1, 12, 7, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 12, 0, 0);
      check_a = 1'b1; addra = 5'd12; req = 1'b0;
      #1;
      chk("pre_rst_busy12", {31'b0, mask[12]}, 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_rst_mask", mask, 32'h0);
      chk("mid_rst_stall", {31'b0, stall}, 32'h0);
      model_clear();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      step(1, 1, 12, 7, 1, 12, 0, 0);
      idle(3, 12);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
